// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: fetch PC, req/ack instruction-memory handshake,
// IF/ID output registers with a one-entry skid buffer for ID freezes.
module if_fetch_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid
);

    typedef enum logic {
        ST_REQ,
        ST_DISCARD
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   hold_addr;
    logic                skid_valid;
    logic [INSTR_W-1:0]  skid_instr;
    logic [ADDR_W-1:0]   skid_pc;
    logic                done;
    logic [ADDR_W-1:0]   fetch_pc_inc;

    // A full skid buffer throttles requests; DISCARD keeps the old transaction alive.
    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            imem_req = (state == ST_DISCARD) || !skid_valid;
        end
        imem_addr = (state == ST_DISCARD) ? hold_addr : fetch_pc;
    end

    assign done         = imem_req && imem_ack;
    assign fetch_pc_inc = fetch_pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_REQ;
            fetch_pc    <= RESET_PC;
            hold_addr   <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            pc          <= '0;
            instruction <= '0;
            valid       <= 1'b0;
        end else if (branch_taken) begin
            valid       <= 1'b0;
            instruction <= '0;
            skid_valid  <= 1'b0;
            fetch_pc    <= branch_addr;
            hold_addr   <= imem_addr;
            state       <= (imem_req && !imem_ack) ? ST_DISCARD : ST_REQ;
        end else if (state == ST_DISCARD) begin
            if (imem_ack) begin
                state <= ST_REQ;
            end
        end else if (freeze) begin
            if (done) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= fetch_pc_inc;
                fetch_pc   <= fetch_pc_inc;
            end
        end else if (skid_valid) begin
            instruction <= skid_instr;
            pc          <= skid_pc;
            valid       <= 1'b1;
            skid_valid  <= 1'b0;
        end else if (done) begin
            instruction <= imem_rdata;
            pc          <= fetch_pc_inc;
            valid       <= 1'b1;
            fetch_pc    <= fetch_pc_inc;
        end else begin
            instruction <= '0;
            valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed stimulus, a latency-programmable
// memory responder, and a queue-based reference model compared every cycle.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .ADDR_W(32),
        .INSTR_W(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .instruction(instruction),
        .valid(valid)
    );

    int checks = 0;
    int errors = 0;
    int unsigned lat = 1;
    int unsigned wcnt = 0;

    // Reference model: outstanding-drop flag, pending-word queue, delivered output.
    logic [31:0] m_fpc, m_drop_addr, m_pc, m_instr;
    bit          m_drop, m_valid;
    logic [63:0] m_buf[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {16'h0, a[31:16]};
    endfunction

    function automatic bit exp_req();
        return m_drop || (m_buf.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_drop ? m_drop_addr : m_fpc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = 32'h0; m_drop_addr = 32'h0; m_drop = 0;
        m_buf.delete();
        m_pc = 32'h0; m_instr = 32'h0; m_valid = 0;
    endtask

    task automatic model_step(input bit f, input bit b, input logic [31:0] ba, input bit ack);
        bit          er;
        logic [31:0] ea;
        logic [63:0] e;
        er = exp_req();
        ea = exp_addr();
        if (b) begin
            m_valid = 0; m_instr = 32'h0;
            m_buf.delete();
            m_drop = er && !ack;
            m_drop_addr = ea;
            m_fpc = ba;
        end else if (m_drop) begin
            if (ack) m_drop = 0;
        end else if (f) begin
            if (er && ack) begin
                m_buf.push_back({word(m_fpc), m_fpc + 32'd4});
                m_fpc = m_fpc + 32'd4;
            end
        end else if (m_buf.size() != 0) begin
            e = m_buf.pop_front();
            m_instr = e[63:32]; m_pc = e[31:0]; m_valid = 1;
        end else if (er && ack) begin
            m_instr = word(m_fpc); m_pc = m_fpc + 32'd4; m_valid = 1;
            m_fpc = m_fpc + 32'd4;
        end else begin
            m_valid = 0; m_instr = 32'h0;
        end
    endtask

    task automatic compare();
        bit er;
        er = rst ? 1'b0 : exp_req();
        check("imem_req", {31'h0, imem_req}, {31'h0, er});
        if (er) check("imem_addr", imem_addr, exp_addr());
        check("pc", pc, m_pc);
        check("instruction", instruction, m_instr);
        check("valid", {31'h0, valid}, {31'h0, m_valid});
    endtask

    // One clock: drive inputs and memory response, advance the model, check after the edge.
    task automatic cyc(input bit f, input bit b, input logic [31:0] ba);
        bit r;
        freeze = f; branch_taken = b; branch_addr = ba;
        r = imem_req;
        imem_ack = imem_req && (wcnt + 1 >= lat);
        imem_rdata = word(imem_addr);
        model_step(f, b, ba, imem_ack);
        @(posedge clk);
        #1;
        if (imem_ack) wcnt = 0;
        else if (r) wcnt++;
        else wcnt = 0;
        imem_ack = 1'b0;
        freeze = 1'b0; branch_taken = 1'b0;
        compare();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        #1;
        model_reset();
        wcnt = 0;
        compare();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;

        // Back-to-back fetches with ack tied high.
        do_reset();
        check("lit_first_req", {31'h0, imem_req}, 32'h1);
        check("lit_first_addr", imem_addr, 32'h0);
        lat = 1;
        cyc(0, 0, 0);
        check("lit_pc4", pc, 32'h4);
        check("lit_instr0", instruction, word(32'h0));
        check("lit_addr4", imem_addr, 32'h4);
        cyc(0, 0, 0);
        check("lit_pc8", pc, 32'h8);
        cyc(0, 0, 0);
        check("lit_pc12", pc, 32'hC);
        check("lit_addr12", imem_addr, 32'hC);

        // Three-cycle memory latency.
        do_reset();
        lat = 3;
        cyc(0, 0, 0);
        check("lit_lat_v1", {31'h0, valid}, 32'h0);
        check("lit_lat_a1", imem_addr, 32'h0);
        cyc(0, 0, 0);
        check("lit_lat_v2", {31'h0, valid}, 32'h0);
        check("lit_lat_a2", imem_addr, 32'h0);
        cyc(0, 0, 0);
        check("lit_lat_pc", pc, 32'h4);
        check("lit_lat_valid", {31'h0, valid}, 32'h1);

        // Freeze four cycles with ack always available.
        lat = 1;
        repeat (4) cyc(1, 0, 0);
        check("lit_frz_pc", pc, 32'h4);
        check("lit_frz_instr", instruction, word(32'h0));
        check("lit_frz_req", {31'h0, imem_req}, 32'h0);
        cyc(0, 0, 0);
        check("lit_rel_pc", pc, 32'h8);
        check("lit_rel_instr", instruction, word(32'h4));
        check("lit_rel_addr", imem_addr, 32'h8);
        cyc(0, 0, 0);
        check("lit_rel_pc2", pc, 32'hC);

        // Branch with ack in the same cycle, then branch over an outstanding fetch.
        cyc(0, 1, 32'h20);
        check("lit_br_valid", {31'h0, valid}, 32'h0);
        check("lit_br_addr", imem_addr, 32'h20);
        lat = 3;
        cyc(0, 0, 0);
        cyc(0, 1, 32'h100);
        check("lit_disc_valid", {31'h0, valid}, 32'h0);
        check("lit_disc_addr", imem_addr, 32'h20);
        cyc(0, 0, 0);
        check("lit_disc_done_addr", imem_addr, 32'h100);
        check("lit_disc_done_valid", {31'h0, valid}, 32'h0);
        lat = 1;
        cyc(0, 0, 0);
        check("lit_tgt_pc", pc, 32'h104);
        check("lit_tgt_instr", instruction, word(32'h100));

        // Branch and freeze together while the skid buffer is full.
        cyc(1, 0, 0);
        check("lit_full_req", {31'h0, imem_req}, 32'h0);
        cyc(1, 1, 32'h200);
        check("lit_bf_valid", {31'h0, valid}, 32'h0);
        check("lit_bf_instr", instruction, 32'h0);
        check("lit_bf_addr", imem_addr, 32'h200);
        cyc(0, 0, 0);
        check("lit_bf_pc", pc, 32'h204);

        // PC wrap, then asynchronous reset in the middle of a wait.
        cyc(0, 1, 32'hFFFF_FFFC);
        check("lit_wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0);
        check("lit_wrap_pc", pc, 32'h0);
        check("lit_wrap_addr", imem_addr, 32'h0);
        check("lit_wrap_instr", instruction, word(32'hFFFF_FFFC));
        lat = 3;
        cyc(1, 0, 0);
        check("lit_wait_valid", {31'h0, valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("lit_arst_req", {31'h0, imem_req}, 32'h0);
        check("lit_arst_instr", instruction, 32'h0);
        check("lit_arst_valid", {31'h0, valid}, 32'h0);
        @(posedge clk);
        #1;
        do_reset();

        // Mixed traffic after reset.
        lat = 2;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 32'h40);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        lat = 1;
        repeat (4) cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
